// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : otter_fetch_queue
// Description : Instruction-fetch front end for the pipelined OTTER.
//               Holds the program counter, issues reads on the synchronous
//               instruction port of program memory, and buffers returned
//               {instruction, pc} pairs in a DEPTH-entry FIFO feeding decode.
//               Decode stalls are absorbed without losing in-flight fetches.
//               A redirect from execute squashes the FIFO and any fetch in
//               flight.
//
// Parameters  : DEPTH    - FIFO entries (power of two, >= 2)
//               RESET_PC - first fetch address after reset
//
// Ports       : CLK       in   clock, all state on rising edge
//               RESET     in   asynchronous active-high reset
//               IMEM_ADDR out  fetch address (current pc)
//               IMEM_RD   out  fetch request
//               IMEM_DOUT in   instruction word, valid the cycle after request
//               FLUSH     in   redirect from execute
//               FLUSH_PC  in   redirect target
//               DE_STALL  in   decode cannot accept this cycle
//               IF_VALID  out  head entry valid for decode
//               IF_IR     out  head instruction (NOP when empty)
//               IF_PC     out  head instruction address (0 when empty)
//
// Build option: OTTER_IFQ_BYPASS_EN - when defined, a response arriving into
//               an empty FIFO is presented to decode combinationally, cutting
//               fetch-to-decode latency from 2 cycles to 1.
//
// Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD,
    input  logic [31:0] IMEM_DOUT,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    input  logic        DE_STALL,
    output logic        IF_VALID,
    output logic [31:0] IF_IR,
    output logic [31:0] IF_PC
);

    localparam int          c_PTR_W   = $clog2(DEPTH);
    localparam int          c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [31:0] c_NOP     = 32'h0000_0013;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]        r_pc;
    logic               r_rsp_v;
    logic [31:0]        r_rsp_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_mem_ir [DEPTH];
    logic [31:0]        r_mem_pc [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] w_occ;
    logic               w_issue;
    logic               w_empty;
    logic               w_byp;
    logic               w_pop;
    logic               w_pop_fifo;
    logic               w_push;

    // Occupancy counts the in-flight request as already holding a slot, so a
    // response can always be written even if decode stalls from here on.
    assign w_occ   = r_count + c_CNT_W'(r_rsp_v);
    assign w_issue = !RESET && (w_occ < c_DEPTH_CNT);
    assign w_empty = (r_count == '0);

    assign IMEM_ADDR = r_pc;
    assign IMEM_RD   = w_issue;

    always_comb begin
        w_byp    = 1'b0;
        IF_VALID = 1'b0;
        IF_IR    = c_NOP;
        IF_PC    = 32'h0000_0000;
        if (!w_empty) begin
            IF_VALID = 1'b1;
            IF_IR    = r_mem_ir[r_rd_ptr];
            IF_PC    = r_mem_pc[r_rd_ptr];
        end
`ifdef OTTER_IFQ_BYPASS_EN
        else if (r_rsp_v) begin
            // Empty queue: hand the arriving word straight to decode.
            w_byp    = 1'b1;
            IF_VALID = 1'b1;
            IF_IR    = IMEM_DOUT;
            IF_PC    = r_rsp_pc;
        end
`endif
    end

    // A redirect freezes the queue for the cycle: nothing leaves, nothing
    // enters, and the contents are discarded at the edge.
    assign w_pop      = IF_VALID && !DE_STALL && !FLUSH;
    assign w_pop_fifo = w_pop && !w_empty;
    // A bypassed word that decode takes this cycle never enters storage.
    assign w_push     = r_rsp_v && !FLUSH && !(w_byp && w_pop);

    // ------------------------------------------------------------------------
    // Program counter and in-flight request tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc     <= RESET_PC;
            r_rsp_v  <= 1'b0;
            r_rsp_pc <= 32'h0000_0000;
        end else if (FLUSH) begin
            // Any fetch issued this cycle belongs to the squashed path.
            r_pc    <= FLUSH_PC;
            r_rsp_v <= 1'b0;
        end else if (w_issue) begin
            r_pc     <= r_pc + 32'd4;
            r_rsp_v  <= 1'b1;
            r_rsp_pc <= r_pc;
        end else begin
            r_rsp_v <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (FLUSH) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_fifo) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop_fifo);
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage (contents are qualified by r_count, so no reset needed)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_ir[r_wr_ptr] <= IMEM_DOUT;
            r_mem_pc[r_wr_ptr] <= r_rsp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_fetch_queue
// Description : Self-checking bench for otter_fetch_queue. A queue-based
//               reference model tracks pc, the in-flight fetch and buffered
//               addresses; outputs are compared every cycle after directed
//               scenarios and a randomized stall/flush/reset phase.
//               Honours OTTER_IFQ_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RD;
    logic [31:0] IMEM_DOUT = 32'h0;
    logic        FLUSH = 1'b0;
    logic [31:0] FLUSH_PC = 32'h0;
    logic        DE_STALL = 1'b0;
    logic        IF_VALID;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC;

    int n_cmp = 0;
    int n_err = 0;

    otter_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_RD(IMEM_RD), .IMEM_DOUT(IMEM_DOUT),
        .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .DE_STALL(DE_STALL),
        .IF_VALID(IF_VALID), .IF_IR(IF_IR), .IF_PC(IF_PC)
    );

    always #5 CLK = ~CLK;

    // Synchronous program memory: word depends only on its address.
    always @(posedge CLK) begin
        if (IMEM_RD) IMEM_DOUT <= IMEM_ADDR ^ KEY;
    end

    // ---------------- reference model ----------------
    logic        m_rst = 1'b1;
    logic [31:0] m_pc = RESET_PC;
    logic        m_inf = 1'b0;
    logic [31:0] m_inf_pc = 32'h0;
    logic [31:0] q[$];

    logic        e_valid, e_rd, e_byp;
    logic [31:0] e_ir, e_pc;

    function automatic void model_expect();
        e_valid = 1'b0; e_ir = NOP; e_pc = 32'h0; e_byp = 1'b0;
        e_rd = !m_rst && ((q.size() + int'(m_inf)) < DEPTH);
        if (!m_rst) begin
            if (q.size() > 0) begin
                e_valid = 1'b1; e_pc = q[0]; e_ir = q[0] ^ KEY;
            end
`ifdef OTTER_IFQ_BYPASS_EN
            else if (m_inf) begin
                e_valid = 1'b1; e_pc = m_inf_pc; e_ir = m_inf_pc ^ KEY; e_byp = 1'b1;
            end
`endif
        end
    endfunction

    function automatic void model_edge(input logic fl, input logic [31:0] fpc, input logic st);
        logic popped;
        model_expect();
        if (m_rst) return;
        if (fl) begin
            q.delete();
            m_inf = 1'b0;
            m_pc  = fpc;
            return;
        end
        popped = e_valid && !st;
        if (popped && !e_byp) void'(q.pop_front());
        if (m_inf && !(popped && e_byp)) q.push_back(m_inf_pc);
        if (e_rd) begin
            m_inf = 1'b1; m_inf_pc = m_pc; m_pc = m_pc + 32'd4;
        end else begin
            m_inf = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        model_expect();
        chk("IF_VALID",  {31'h0, IF_VALID}, {31'h0, e_valid});
        chk("IF_PC",     IF_PC, e_pc);
        chk("IF_IR",     IF_IR, e_ir);
        chk("IMEM_RD",   {31'h0, IMEM_RD}, {31'h0, e_rd});
        chk("IMEM_ADDR", IMEM_ADDR, m_pc);
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance.
    task automatic step(input logic rst, input logic fl, input logic [31:0] fpc, input logic st);
        RESET = rst; FLUSH = fl; FLUSH_PC = fpc; DE_STALL = st;
        if (rst) begin
            m_rst = 1'b1; q.delete(); m_inf = 1'b0; m_pc = RESET_PC;
        end else begin
            m_rst = 1'b0;
        end
        #1;
        check_all();
        @(posedge CLK);
        model_edge(fl, fpc, st);
        @(negedge CLK);
    endtask

    task automatic run(input int n, input logic st);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, st);
    endtask

    int saw_wrap;

    initial begin
        @(negedge CLK);
        // Reset state
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Release and stream with no stall
        run(12, 1'b0);

        // Hold stall 10 cycles, then release
        run(10, 1'b1);
        run(8, 1'b0);

        // Fill, then flush while full with a request in flight
        run(6, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        run(6, 1'b0);

        // Back-to-back flushes
        step(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0400, 1'b0);
        run(6, 1'b0);

        // Address wrap
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        saw_wrap = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_rst == 1'b0 && q.size() > 0 && q[0] == 32'h0) saw_wrap = 1;
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        chk("wrap_seen", saw_wrap, 1);

        // Mid-stream asynchronous reset between edges
        run(3, 1'b1);
        RESET = 1'b1;
        #2;
        chk("async_rst_valid", {31'h0, IF_VALID}, 32'h0);
        chk("async_rst_rd",    {31'h0, IMEM_RD},  32'h0);
        chk("async_rst_addr",  IMEM_ADDR, RESET_PC);
        @(negedge CLK);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        run(6, 1'b0);

        // Randomized stall / flush / occasional reset
        for (int i = 0; i < 600; i++) begin
            int r;
            logic rst, fl, st;
            logic [31:0] fpc;
            r   = $urandom_range(0, 99);
            rst = (r < 2);
            fl  = (r >= 2) && (r < 8);
            st  = ($urandom_range(0, 2) == 0);
            fpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 9) == 0) fpc = 32'hFFFF_FFF0;
            step(rst, fl, fpc, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
